// File: rtl/neopixel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// neopixel_pkg: shared types and constants for the NeoPixel frame scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
package neopixel_pkg;

  localparam int MaxNumNeoPixel = 64;
  localparam int PixelWidth     = 24;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sched_state_t;

  // (ch * (level + 1)) >> 8; level 255 is identity, level 0 blanks the channel.
  function automatic logic [7:0] scale_channel(input logic [7:0] ch, input logic [7:0] level);
    logic [15:0] prod;
    prod = {8'd0, ch} * ({8'd0, level} + 16'd1);
    return prod[15:8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/neopixel_frame_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// neopixel_frame_buffer: one-frame GRB pixel store, 1 write port, async read.
// Revision: 1.0
// ---------------------------------------------------------------------------
module neopixel_frame_buffer
  import neopixel_pkg::*;
#(
  parameter int MaxNumPixel = MaxNumNeoPixel,
  localparam int AddrW      = $clog2(MaxNumPixel)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AddrW-1:0]      waddr,
  input  logic [PixelWidth-1:0] wdata,
  input  logic [AddrW-1:0]      raddr,
  output logic [PixelWidth-1:0] rdata
);

  logic [PixelWidth-1:0] mem [MaxNumPixel];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MaxNumPixel; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Async read gives read-before-write when raddr == waddr in the same cycle.
  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/neopixel_frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// neopixel_frame_scheduler: streams a stored frame into the pixel FIFO on trigger
// or refresh period. Optional: NEOPIXEL_BRIGHTNESS_EN adds per-channel scaling.
// Revision: 1.0
// ---------------------------------------------------------------------------
module neopixel_frame_scheduler
  import neopixel_pkg::*;
#(
  parameter int MaxNumPixel  = MaxNumNeoPixel,
  parameter int RefreshWidth = 24,
  localparam int AddrW       = $clog2(MaxNumPixel)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    trigger_i,
  input  logic [AddrW:0]          num_pixel_i,
  input  logic [RefreshWidth-1:0] refresh_period_i,
  input  logic                    fb_we_i,
  input  logic [AddrW-1:0]        fb_addr_i,
  input  logic [PixelWidth-1:0]   fb_wdata_i,
  input  logic                    fifo_full_i,
`ifdef NEOPIXEL_BRIGHTNESS_EN
  input  logic [7:0]              brightness_i,
`endif
  output logic                    fifo_push_o,
  output logic [PixelWidth-1:0]   fifo_data_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic [15:0]             frame_cnt_o
);

  localparam logic [RefreshWidth-1:0] TimerOne = RefreshWidth'(1);
  localparam logic [AddrW:0]          LenOne   = (AddrW + 1)'(1);
  localparam logic [AddrW:0]          MaxLen   = (AddrW + 1)'(MaxNumPixel);
  localparam logic [AddrW-1:0]        IdxOne   = AddrW'(1);

  sched_state_t            state;
  sched_state_t            state_next;
  logic [RefreshWidth-1:0] timer;
  logic [AddrW-1:0]        rd_idx;
  logic [AddrW:0]          frame_len;
  logic [AddrW:0]          start_len;
  logic [PixelWidth-1:0]   rd_word;
  logic [PixelWidth-1:0]   pixel_out;
  logic                    timer_run;
  logic                    timer_hit;
  logic                    start_evt;
  logic                    push;
  logic                    last_push;

  neopixel_frame_buffer #(
    .MaxNumPixel (MaxNumPixel)
  ) u_frame_buffer (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (fb_we_i),
    .waddr (fb_addr_i),
    .wdata (fb_wdata_i),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  // Timer runs in both states so the refresh period is measured start-to-start.
  assign timer_run = enable_i && (refresh_period_i != '0);
  assign timer_hit = timer_run && (timer == (refresh_period_i - TimerOne));
  assign start_evt = trigger_i || timer_hit;
  assign start_len = (num_pixel_i > MaxLen) ? MaxLen : num_pixel_i;
  assign push      = (state == STREAM) && !fifo_full_i;
  assign last_push = push && ({1'b0, rd_idx} == (frame_len - LenOne));

`ifdef NEOPIXEL_BRIGHTNESS_EN
  assign pixel_out = {scale_channel(rd_word[23:16], brightness_i),
                      scale_channel(rd_word[15:8],  brightness_i),
                      scale_channel(rd_word[7:0],   brightness_i)};
`else
  assign pixel_out = rd_word;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_evt && (start_len != '0)) state_next = STREAM;
      STREAM:  if (last_push) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_push_o = 1'b0;
    fifo_data_o = '0;
    busy_o      = 1'b0;
    overrun_o   = 1'b0;
    if (state == STREAM) begin
      busy_o      = 1'b1;
      fifo_push_o = push;
      fifo_data_o = pixel_out;
      overrun_o   = start_evt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer       <= '0;
      rd_idx      <= '0;
      frame_len   <= '0;
      frame_cnt_o <= '0;
    end else begin
      // Any start event, accepted or dropped, restarts the period.
      if (start_evt) begin
        timer <= '0;
      end else if (timer_run) begin
        timer <= timer + TimerOne;
      end

      if ((state == IDLE) && start_evt) begin
        rd_idx    <= '0;
        frame_len <= start_len;
      end else if (push) begin
        rd_idx <= rd_idx + IdxOne;
      end

      if (last_push) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
